// File: rtl/result_display_driver_if.sv
// Result/display bundle between the calculator result register
// and the four-digit seven-segment driver.
interface result_display_driver_if;
  logic [8:0] result;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;
  logic       busy;

  modport master (
    output result,
    input  seg, an, dp, busy
  );

  modport slave (
    input  result,
    output seg, an, dp, busy
  );
endinterface

// File: rtl/result_display_driver.sv
// Double-dabble binary-to-BCD converter plus multiplexed 4-digit display.
// Define SIGNED_DISPLAY_EN to treat result as two's complement with a '-' digit.
module result_display_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input logic                     clk,
  input logic                     reset,
  result_display_driver_if.slave  bus
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  state_t      state, state_nxt;
  logic [8:0]  last_value;
  logic [8:0]  bin_q;
  logic [11:0] bcd_q;
  logic [11:0] bcd_adj;
  logic [3:0]  iter;
  logic [3:0]  hund, tens, ones;
  logic [8:0]  mag;
  logic        neg_disp;
  logic        start, shift_en, load_en, busy_nxt;
  logic        busy_q;
  logic [CW-1:0] cnt;
  logic [1:0]  sel;
  logic [6:0]  seg_q, seg_nxt;
  logic [3:0]  an_q;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

`ifdef SIGNED_DISPLAY_EN
  logic neg_q;
  // -256 wraps to 9'h100, read as unsigned 256
  assign mag = bus.result[8] ? (~bus.result + 9'd1) : bus.result;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      neg_q    <= 1'b0;
      neg_disp <= 1'b0;
    end else begin
      if (start)   neg_q    <= bus.result[8];
      if (load_en) neg_disp <= neg_q;
    end
  end
`else
  assign mag      = bus.result;
  assign neg_disp = 1'b0;
`endif

  assign bcd_adj = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (bus.result != last_value) state_nxt = SHIFT;
      SHIFT: if (iter == 4'd8)             state_nxt = LOAD;
      LOAD:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start    = (state == IDLE) && (bus.result != last_value);
    shift_en = (state == SHIFT);
    load_en  = (state == LOAD);
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_value <= '0;
      bin_q      <= '0;
      bcd_q      <= '0;
      iter       <= '0;
      hund       <= '0;
      tens       <= '0;
      ones       <= '0;
      busy_q     <= 1'b0;
    end else begin
      busy_q <= busy_nxt;
      if (start) begin
        last_value <= bus.result;
        bin_q      <= mag;
        bcd_q      <= '0;
        iter       <= '0;
      end
      if (shift_en) begin
        {bcd_q, bin_q} <= {bcd_adj[10:0], bin_q, 1'b0};
        iter           <= iter + 4'd1;
      end
      if (load_en) begin
        hund <= bcd_q[11:8];
        tens <= bcd_q[7:4];
        ones <= bcd_q[3:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      sel <= '0;
    end else if (cnt == CW'(REFRESH_DIV - 1)) begin
      cnt <= '0;
      sel <= sel + 2'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Leading zeros blank; digit 3 only ever carries the sign
  always_comb begin
    seg_nxt = 7'h7F;
    case (sel)
      2'd0: seg_nxt = seg_code(ones);
      2'd1: if (hund != 4'd0 || tens != 4'd0) seg_nxt = seg_code(tens);
      2'd2: if (hund != 4'd0) seg_nxt = seg_code(hund);
      2'd3: if (neg_disp) seg_nxt = 7'b0111111;
      default: seg_nxt = 7'h7F;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_q <= 7'h7F;
      an_q  <= 4'hF;
    end else begin
      seg_q <= seg_nxt;
      an_q  <= ~(4'b0001 << sel);
    end
  end

  assign bus.seg  = seg_q;
  assign bus.an   = an_q;
  assign bus.dp   = 1'b1;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_result_display_driver.sv
// Randomized self-checking bench for result_display_driver against a
// decimal-arithmetic reference model.
module tb_result_display_driver;

  localparam int DIV = 4;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  result_display_driver_if bus ();

  result_display_driver #(.REFRESH_DIV(DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] dec_code(input int d);
    logic [6:0] t [10];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
          7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return t[d];
  endfunction

  function automatic logic [6:0] exp_seg(input logic [8:0] v, input int d);
    int mag, h, t, o;
    bit neg;
`ifdef SIGNED_DISPLAY_EN
    neg = v[8];
    mag = neg ? 512 - int'(v) : int'(v);
`else
    neg = 1'b0;
    mag = int'(v);
`endif
    h = mag / 100;
    t = (mag / 10) % 10;
    o = mag % 10;
    case (d)
      0: return dec_code(o);
      1: return (h == 0 && t == 0) ? 7'h7F : dec_code(t);
      2: return (h == 0) ? 7'h7F : dec_code(h);
      default: return neg ? 7'b0111111 : 7'h7F;
    endcase
  endfunction

  function automatic int an_digit(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic check_cur(input logic [8:0] v, input string tag);
    int d;
    d = an_digit(bus.an);
    if (d < 0) check_eq({tag, "_an"}, bus.an, 4'hE);
    else check_eq($sformatf("%s_d%0d", tag, d), bus.seg, exp_seg(v, d));
  endtask

  task automatic scan(input logic [8:0] v, input string tag);
    for (int d = 0; d < 4; d++) begin
      int n;
      n = 0;
      while (an_digit(bus.an) != d && n < 40) begin
        @(negedge clk);
        n++;
      end
      if (n >= 40)
        check_eq($sformatf("%s_timeout_d%0d", tag, d), 0, 1);
      else
        check_eq($sformatf("%s_v%0d_d%0d", tag, v, d), bus.seg,
                 exp_seg(v, d));
    end
    check_eq({tag, "_dp"}, bus.dp, 1'b1);
  endtask

  task automatic settle(input logic [8:0] v, input string tag);
    bus.result = v;
    repeat (12) @(negedge clk);
    check_eq({tag, "_busy"}, bus.busy, 1'b0);
    scan(v, tag);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_seg"}, bus.seg, 7'h7F);
    check_eq({tag, "_an"}, bus.an, 4'hF);
    check_eq({tag, "_dp"}, bus.dp, 1'b1);
    check_eq({tag, "_busy"}, bus.busy, 1'b0);
  endtask

  initial begin
    logic [8:0] dir [12];
    logic [8:0] a, b;
    checks   = 0;
    failures = 0;
    dir = '{9'd511, 9'd7, 9'd70, 9'h1FF, 9'h100, 9'h0FF,
            9'd1, 9'd10, 9'd99, 9'd100, 9'd256, 9'd0};

    reset      = 1'b1;
    bus.result = 9'd0;
    #2;
    check_reset_vals("rst_hold");
    repeat (3) @(negedge clk);
    check_reset_vals("rst_hold2");
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_eq("zero_busy", bus.busy, 1'b0);
    end
    scan(9'd0, "zero");

    bus.result = 9'd345;
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      check_eq($sformatf("b345_busy_e%0d", k), bus.busy, 1'b1);
      @(negedge clk);
    end
    check_eq("b345_busy_e10", bus.busy, 1'b0);
    @(negedge clk);
    check_cur(9'd345, "lat345");
    scan(9'd345, "s345");

    foreach (dir[i]) settle(dir[i], "dir");

    settle(9'd0, "pre100");
    bus.result = 9'd100;
    @(negedge clk);
    repeat (2) @(negedge clk);
    bus.result = 9'd200;
    repeat (8) @(negedge clk);
    check_eq("r100_busy_e10", bus.busy, 1'b0);
    @(negedge clk);
    check_eq("r200_busy_e11", bus.busy, 1'b1);
    check_cur(9'd100, "show100");
    for (int k = 12; k < 22; k++) begin
      @(negedge clk);
      check_cur(9'd100, "hold100");
    end
    @(negedge clk);
    check_cur(9'd200, "lat200");
    scan(9'd200, "s200");

    settle(9'd0, "pre123");
    bus.result = 9'd123;
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_reset_vals("rst_mid");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("r123_busy_e0", bus.busy, 1'b1);
    repeat (10) @(negedge clk);
    check_eq("r123_busy_e10", bus.busy, 1'b0);
    @(negedge clk);
    check_cur(9'd123, "lat123");
    scan(9'd123, "s123");

    for (int i = 0; i < 25; i++) begin
      a = 9'($urandom_range(0, 511));
      settle(a, "rnd");
    end

    for (int i = 0; i < 10; i++) begin
      a = 9'($urandom_range(0, 511));
      b = 9'($urandom_range(0, 511));
      bus.result = a;
      repeat ($urandom_range(1, 9)) @(negedge clk);
      bus.result = b;
      repeat (30) @(negedge clk);
      check_eq("chg_busy", bus.busy, 1'b0);
      scan(b, "chg");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=0 exp=1");
    $fatal(1, "timeout");
  end

endmodule
